// File: rtl/cc_pkg.sv
// Shared types and constants for the class-ranking result transmitter.
package cc_pkg;
    localparam int NUM_STU = 7;
    localparam int ID_W    = 3;
    localparam int BEAT_W  = 4;
    localparam int HDR_BIT = 3;

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;
    typedef logic [ID_W-1:0] id_t;

    function automatic logic [BEAT_W-1:0] mk_beat(input logic hdr, input id_t v);
        logic [BEAT_W-1:0] b;
        b                = '0;
        b[ID_W-1:0]      = v;
        b[HDR_BIT]       = hdr;
        return b;
    endfunction
endpackage

// File: rtl/cc_perm_check.sv
// Checks that seven student IDs form a permutation of 0..6.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module cc_perm_check
    import cc_pkg::*;
(
    input  id_t [NUM_STU-1:0] ids,
    output logic              ok
);
    logic [NUM_STU-1:0] seen;
    logic               any7;

    always_comb begin
        seen = '0;
        any7 = 1'b0;
        for (int i = 0; i < NUM_STU; i++) begin
            // An ID of 7 shifts out of the 7-bit vector, so it also flags separately.
            seen = seen | (7'b1 << ids[i]);
            if (ids[i] == 3'd7) any7 = 1'b1;
        end
        ok = (seen == 7'h7F) && !any7;
    end
endmodule

// File: rtl/cc_rank_tx.sv
// Captures one ranking result and streams it as header, IDs, XOR trailer beats.
// Latency: header valid one cycle after capture; one beat per cycle when unstalled.
// Backpressure: out_valid/out_data/out_last hold until out_ready; in_ready only in IDLE.
module cc_rank_tx
    import cc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   s_id0,
    input  logic [ID_W-1:0]   s_id1,
    input  logic [ID_W-1:0]   s_id2,
    input  logic [ID_W-1:0]   s_id3,
    input  logic [ID_W-1:0]   s_id4,
    input  logic [ID_W-1:0]   s_id5,
    input  logic [ID_W-1:0]   s_id6,
    input  logic [2:0]        cnt,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic              err
);
    state_t              state_q, state_d;
    id_t [NUM_STU-1:0]   ids_q, ids_d, ids_in;
    logic [2:0]          n_q, n_d;
    logic [2:0]          idx_q, idx_d, idx_nxt;
    id_t                 chk_q, chk_d;
    logic                vld_d, last_d, err_d;
    logic [BEAT_W-1:0]   data_d;
    logic                perm_ok, capture, hs;

    assign ids_in = {s_id6, s_id5, s_id4, s_id3, s_id2, s_id1, s_id0};

    cc_perm_check u_perm (
        .ids (ids_in),
        .ok  (perm_ok)
    );

    assign in_ready = (state_q == IDLE);
    assign capture  = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign idx_nxt  = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        ids_d   = ids_q;
        n_d     = n_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        vld_d   = out_valid;
        data_d  = out_data;
        last_d  = out_last;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    if (perm_ok) begin
                        state_d = HEAD;
                        ids_d   = ids_in;
                        n_d     = mode ? cnt : 3'(NUM_STU);
                        idx_d   = '0;
                        chk_d   = '0;
                        vld_d   = 1'b1;
                        data_d  = mk_beat(1'b1, cnt);
                        last_d  = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            HEAD: begin
                if (hs) begin
                    if (n_q != 3'd0) begin
                        state_d = BODY;
                        idx_d   = '0;
                        data_d  = mk_beat(1'b0, ids_q[0]);
                        chk_d   = ids_q[0];
                    end else begin
                        state_d = TAIL;
                        data_d  = mk_beat(1'b0, chk_q);
                        last_d  = 1'b1;
                    end
                end
            end
            BODY: begin
                if (hs) begin
                    // Checksum already includes the ID just accepted.
                    if (idx_q == n_q - 3'd1) begin
                        state_d = TAIL;
                        data_d  = mk_beat(1'b0, chk_q);
                        last_d  = 1'b1;
                    end else begin
                        idx_d   = idx_nxt;
                        data_d  = mk_beat(1'b0, ids_q[idx_nxt]);
                        chk_d   = chk_q ^ ids_q[idx_nxt];
                    end
                end
            end
            TAIL: begin
                if (hs) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ids_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            ids_q     <= ids_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            out_valid <= vld_d;
            out_data  <= data_d;
            out_last  <= last_d;
            err       <= err_d;
        end
    end
endmodule
